ipml_sync_fifo_v2_0_mat_fifo: RTL and testbench
===============================================

Name: ipml_sync_fifo_v2_0_mat_fifo

Overview:
Single-clock, parametrised FIFO for the mat pipeline. It replaces the dual-clock SDPRAM-plus-controller FIFO on paths where producer and consumer share one clock. It adds a run-time first-word-fall-through (FWFT) mode, run-time almost-full/almost-empty thresholds, a synchronous flush, and overflow/underflow error reporting. Storage is an inferred RAM with a one-cycle registered read.

Parameters:
c_DATA_WIDTH, 32, data width in bits (1..1152).
c_DEPTH_WIDTH, 10, log2 of depth; capacity is 2^c_DEPTH_WIDTH words (4..20).
c_FWFT, 0, 0 = standard read (data one cycle after rd_en); 1 = FWFT.
c_AF_RST, 2^c_DEPTH_WIDTH-4, almost_full threshold loaded at reset.
c_AE_RST, 4, almost_empty threshold loaded at reset.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  synchronous flush, active high.
wr_data  in  c_DATA_WIDTH  write data.
wr_en  in  1  write request.
wr_full  out  1  full flag.
almost_full  out  1  level >= af_thresh.
rd_data  out  c_DATA_WIDTH  read data.
rd_en  in  1  read request (FWFT: pop/acknowledge).
rd_empty  out  1  empty flag.
almost_empty  out  1  level <= ae_thresh.
water_level  out  c_DEPTH_WIDTH+1  words held, including the FWFT output word.
thr_wr  in  1  load the thresholds from af_thresh_in and ae_thresh_in.
af_thresh_in  in  c_DEPTH_WIDTH+1  new almost_full threshold.
ae_thresh_in  in  c_DEPTH_WIDTH+1  new almost_empty threshold.
overflow  out  1  one-cycle pulse on a rejected write.
underflow  out  1  one-cycle pulse on a rejected read.
err_sticky  out  2  {overflow, underflow} sticky bits.
err_clr  in  1  clears err_sticky.

Behaviour:
- Reset (rst_n=0, asynchronous): pointers=0, water_level=0, rd_empty=1, wr_full=0, almost_empty=1, almost_full=(c_AF_RST==0), rd_data=0, overflow=underflow=0, err_sticky=0, thresholds=c_AF_RST/c_AE_RST.
- All flags are registered.
- Write acceptance: accepted iff wr_en && !wr_full. Read acceptance: accepted iff rd_en && !rd_empty. Both decisions use registered flags; there is no look-ahead.
- Capacity is 2^c_DEPTH_WIDTH words in both modes.
- Pointers are c_DEPTH_WIDTH bits and wrap naturally.
- water_level updates the cycle after an accepted operation: +1 for a write only, -1 for a read only, unchanged when both are accepted.
- wr_full = (level == 2^c_DEPTH_WIDTH). rd_empty = (no word available to the read port).
- Full with rd_en && wr_en: the read is accepted, the write is rejected (overflow pulse); level drops by 1.
- Empty with rd_en && wr_en: the write is accepted, the read is rejected (underflow pulse).
- Standard mode (c_FWFT=0):
  - Write at cycle N: rd_empty deasserts at N+1.
  - Accepted read at N: rd_data valid at N+1 and held until the next accepted read.
- FWFT mode (c_FWFT=1):
  - The output register prefetches from RAM; there are two states, OUT_EMPTY and OUT_VALID.
  - Write into an empty FIFO at N: RAM read at N+1, rd_data valid and rd_empty=0 at N+2.
  - An accepted rd_en presents the next word on the following cycle with no bubble while RAM is non-empty.
  - rd_data holds its last value when empty.
- Thresholds:
  - thr_wr loads both thresholds; the flags reflect the new thresholds on the next cycle.
  - Threshold values above 2^c_DEPTH_WIDTH are saturated to that value.
- Errors:
  - overflow = wr_en && wr_full. underflow = rd_en && rd_empty.
  - err_sticky bits set on the respective pulse.
  - err_clr clears err_sticky; a set in the same cycle as err_clr wins.
- clr:
  - Has priority over rd/wr in the same cycle.
  - Next cycle: pointers, level and flags take their reset values.
  - rd_data, thresholds and err_sticky are retained.
  - Writes and reads presented with clr are discarded without error pulses.
- rst_n assertion mid-operation aborts everything immediately. The first write is accepted in the first cycle after rst_n deassertion.

Optional Feature:
MAT_FIFO_PEAK_LEVEL_EN:
- Defined: adds output peak_level [c_DEPTH_WIDTH:0], the registered maximum of water_level since reset or clr. It is cleared by err_clr and tracks a new maximum one cycle after water_level.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package mat_fifo_pkg holds:
  - the FWFT output-state enum (OUT_EMPTY, OUT_VALID);
  - the error-bit index constants ERR_OVF=1, ERR_UDF=0;
  - the threshold-saturation function.
- One sub-module, mat_fifo_ram: inferred simple dual-port RAM, one write port, registered read with read enable. The controller stays in the top module.

Test Plan:
1. Std mode, c_DEPTH_WIDTH=4, width 8. Write 0x00..0x0F over 16 cycles -> wr_full=1 after the 16th write, water_level=16, almost_full from level 12 up. Then 16 reads -> data 0x00..0x0F in order, each one cycle after rd_en, rd_empty=1 after the last read.
2. FWFT mode. Single write 0xA5 at cycle N -> rd_empty=0 and rd_data=0xA5 at N+2. rd_en at N+2 -> rd_empty=1 at N+3.
3. Full FIFO with wr_en=rd_en=1 for one cycle -> overflow pulse, err_sticky=2'b10, level 15, oldest word read. Empty FIFO with both asserted -> underflow pulse, level 1.
4. Continuous write+read for 40 cycles at level 5 -> level stays 5, pointers wrap, output sequence unbroken (counter data, no gaps or duplicates).
5. thr_wr with af=20, ae=0 at depth 16 -> thresholds saturate to 16; almost_full only when full; almost_empty only at level 0.
6. clr at level 9 with wr_en high -> next cycle level 0, rd_empty=1, no overflow pulse, err_sticky unchanged. Assert rst_n=0 mid-burst -> all outputs reset asynchronously within the same cycle.

Source files
------------

// File: rtl/mat_fifo_pkg.sv
// Shared types and helpers for the single-clock mat pipeline FIFO.
package mat_fifo_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  localparam int ERR_OVF = 1;
  localparam int ERR_UDF = 0;

  // Clamp a requested threshold to the FIFO capacity.
  function automatic int unsigned sat_thresh(input int unsigned val, input int unsigned limit);
    return (val > limit) ? limit : val;
  endfunction

endpackage

// File: rtl/mat_fifo_ram.sv
// Inferred simple dual-port RAM: one write port, registered read with read enable.
module mat_fifo_ram
  import mat_fifo_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = 32,
  parameter int unsigned c_ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [c_ADDR_WIDTH-1:0] waddr,
  input  logic [c_DATA_WIDTH-1:0] wdata,
  input  logic                    re,
  input  logic [c_ADDR_WIDTH-1:0] raddr,
  output logic [c_DATA_WIDTH-1:0] rdata
);

  logic [c_DATA_WIDTH-1:0] mem [0:(1<<c_ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset so the array still maps onto block RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ipml_sync_fifo_v2_0_mat_fifo.sv
// Single-clock FIFO with optional FWFT output stage, run-time thresholds, flush and error flags.
// Optional peak water-level tracking: define MAT_FIFO_PEAK_LEVEL_EN.
//   state     | meaning
//   OUT_EMPTY | output register holds no unread word (rd_empty=1)
//   OUT_VALID | output register holds the next word to pop
module ipml_sync_fifo_v2_0_mat_fifo
  import mat_fifo_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH  = 32,
  parameter int unsigned c_DEPTH_WIDTH = 10,
  parameter int unsigned c_FWFT        = 0,
  parameter int unsigned c_AF_RST      = (1 << c_DEPTH_WIDTH) - 4,
  parameter int unsigned c_AE_RST      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [c_DATA_WIDTH-1:0]  wr_data,
  input  logic                     wr_en,
  output logic                     wr_full,
  output logic                     almost_full,
  output logic [c_DATA_WIDTH-1:0]  rd_data,
  input  logic                     rd_en,
  output logic                     rd_empty,
  output logic                     almost_empty,
  output logic [c_DEPTH_WIDTH:0]   water_level,
  input  logic                     thr_wr,
  input  logic [c_DEPTH_WIDTH:0]   af_thresh_in,
  input  logic [c_DEPTH_WIDTH:0]   ae_thresh_in,
  output logic                     overflow,
  output logic                     underflow,
  output logic [1:0]               err_sticky,
  input  logic                     err_clr
`ifdef MAT_FIFO_PEAK_LEVEL_EN
  ,
  output logic [c_DEPTH_WIDTH:0]   peak_level
`endif
);

  localparam int unsigned LW         = c_DEPTH_WIDTH + 1;
  localparam int unsigned DEPTH      = 1 << c_DEPTH_WIDTH;
  localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
  localparam logic [LW-1:0] AF_RST_SAT = LW'(sat_thresh(c_AF_RST, DEPTH));
  localparam logic [LW-1:0] AE_RST_SAT = LW'(sat_thresh(c_AE_RST, DEPTH));

  logic [c_DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]            ram_cnt, ram_cnt_nxt, level_nxt;
  logic [LW-1:0]            af_thr, ae_thr, af_nxt, ae_nxt;
  out_state_e               out_state, out_state_nxt;
  logic                     wr_acc, rd_acc, ram_re;

  always_comb begin
    wr_acc        = wr_en && !wr_full && !clr;
    rd_acc        = rd_en && !rd_empty && !clr;
    level_nxt     = water_level;
    ram_re        = 1'b0;
    ram_cnt_nxt   = ram_cnt;
    out_state_nxt = out_state;

    case ({wr_acc, rd_acc})
      2'b10:   level_nxt = water_level + LW'(1);
      2'b01:   level_nxt = water_level - LW'(1);
      default: level_nxt = water_level;
    endcase
    if (clr) level_nxt = '0;

    if (c_FWFT != 0) begin
      // Refill the output register whenever it is empty or being popped.
      ram_re      = !clr && (ram_cnt != '0) && ((out_state == OUT_EMPTY) || rd_acc);
      ram_cnt_nxt = ram_cnt + LW'(wr_acc) - LW'(ram_re);
      if (ram_re)      out_state_nxt = OUT_VALID;
      else if (rd_acc) out_state_nxt = OUT_EMPTY;
    end else begin
      ram_re        = rd_acc;
      ram_cnt_nxt   = level_nxt;
      out_state_nxt = (level_nxt != '0) ? OUT_VALID : OUT_EMPTY;
    end

    if (clr) begin
      ram_cnt_nxt   = '0;
      out_state_nxt = OUT_EMPTY;
    end

    af_nxt = thr_wr ? LW'(sat_thresh(32'(af_thresh_in), DEPTH)) : af_thr;
    ae_nxt = thr_wr ? LW'(sat_thresh(32'(ae_thresh_in), DEPTH)) : ae_thr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      water_level  <= '0;
      out_state    <= OUT_EMPTY;
      wr_full      <= 1'b0;
      rd_empty     <= 1'b1;
      almost_full  <= (AF_RST_SAT == '0);
      almost_empty <= 1'b1;
      af_thr       <= AF_RST_SAT;
      ae_thr       <= AE_RST_SAT;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      err_sticky   <= '0;
    end else begin
      if (clr)         wr_ptr <= '0;
      else if (wr_acc) wr_ptr <= wr_ptr + c_DEPTH_WIDTH'(1);
      if (clr)         rd_ptr <= '0;
      else if (ram_re) rd_ptr <= rd_ptr + c_DEPTH_WIDTH'(1);

      ram_cnt      <= ram_cnt_nxt;
      water_level  <= level_nxt;
      out_state    <= out_state_nxt;
      wr_full      <= (level_nxt == FULL_LVL);
      rd_empty     <= (out_state_nxt == OUT_EMPTY);
      almost_full  <= (level_nxt >= af_nxt);
      almost_empty <= (level_nxt <= ae_nxt);
      af_thr       <= af_nxt;
      ae_thr       <= ae_nxt;

      overflow  <= wr_en && wr_full && !clr;
      underflow <= rd_en && rd_empty && !clr;
      // A new error in the same cycle as err_clr stays set.
      err_sticky[ERR_OVF] <= (wr_en && wr_full && !clr) | (err_sticky[ERR_OVF] & ~err_clr);
      err_sticky[ERR_UDF] <= (rd_en && rd_empty && !clr) | (err_sticky[ERR_UDF] & ~err_clr);
    end
  end

`ifdef MAT_FIFO_PEAK_LEVEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       peak_level <= '0;
    else if (clr || err_clr)          peak_level <= '0;
    else if (water_level > peak_level) peak_level <= water_level;
  end
`endif

  mat_fifo_ram #(
    .c_DATA_WIDTH (c_DATA_WIDTH),
    .c_ADDR_WIDTH (c_DEPTH_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_ipml_sync_fifo_v2_0_mat_fifo.sv
// Drives a standard and an FWFT instance with shared inputs against a queue-based model.
module tb_ipml_sync_fifo_v2_0_mat_fifo;

  localparam int DW = 8, AW = 4, DEPTH = 16, LW = 5, AF_RST = 12, AE_RST = 4;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic thr_wr = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [LW-1:0] af_in = '0, ae_in = '0;

  logic s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
  logic [DW-1:0] s_rd;
  logic [LW-1:0] s_lvl;
  logic [1:0]    s_st;
  logic f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
  logic [DW-1:0] f_rd;
  logic [LW-1:0] f_lvl;
  logic [1:0]    f_st;
`ifdef MAT_FIFO_PEAK_LEVEL_EN
  logic [LW-1:0] s_peak, f_peak;
`endif

  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  ipml_sync_fifo_v2_0_mat_fifo #(
    .c_DATA_WIDTH(DW), .c_DEPTH_WIDTH(AW), .c_FWFT(0), .c_AF_RST(AF_RST), .c_AE_RST(AE_RST)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_data(wr_data), .wr_en(wr_en),
    .wr_full(s_full), .almost_full(s_af), .rd_data(s_rd), .rd_en(rd_en),
    .rd_empty(s_empty), .almost_empty(s_ae), .water_level(s_lvl), .thr_wr(thr_wr),
    .af_thresh_in(af_in), .ae_thresh_in(ae_in), .overflow(s_ovf), .underflow(s_udf),
    .err_sticky(s_st), .err_clr(err_clr)
`ifdef MAT_FIFO_PEAK_LEVEL_EN
    , .peak_level(s_peak)
`endif
  );

  ipml_sync_fifo_v2_0_mat_fifo #(
    .c_DATA_WIDTH(DW), .c_DEPTH_WIDTH(AW), .c_FWFT(1), .c_AF_RST(AF_RST), .c_AE_RST(AE_RST)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_data(wr_data), .wr_en(wr_en),
    .wr_full(f_full), .almost_full(f_af), .rd_data(f_rd), .rd_en(rd_en),
    .rd_empty(f_empty), .almost_empty(f_ae), .water_level(f_lvl), .thr_wr(thr_wr),
    .af_thresh_in(af_in), .ae_thresh_in(ae_in), .overflow(f_ovf), .underflow(f_udf),
    .err_sticky(f_st), .err_clr(err_clr)
`ifdef MAT_FIFO_PEAK_LEVEL_EN
    , .peak_level(f_peak)
`endif
  );

  // Reference model: sq holds the standard FIFO contents; fq holds the FWFT words
  // still in storage, f_ov says whether a word is presented at the FWFT output.
  logic [DW-1:0] sq[$], fq[$];
  bit            f_ov;
  int            af_t, ae_t, e_speak, e_fpeak;
  logic [DW-1:0] e_srd, e_frd;
  bit            e_sovf, e_sudf, e_fovf, e_fudf;
  logic [1:0]    e_sst, e_fst;

  task automatic model_reset();
    sq.delete(); fq.delete();
    f_ov = 0; af_t = AF_RST; ae_t = AE_RST; e_speak = 0; e_fpeak = 0;
    e_srd = '0; e_frd = '0;
    e_sovf = 0; e_sudf = 0; e_fovf = 0; e_fudf = 0; e_sst = '0; e_fst = '0;
  endtask

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step();
    int  sl, fl;
    bit  s_fl, s_em, f_fl, rd_ok, fetch;
    sl   = sq.size();
    fl   = fq.size() + int'(f_ov);
    s_fl = (sl == DEPTH); s_em = (sl == 0);
    f_fl = (fl == DEPTH);
    e_speak = (clr || err_clr) ? 0 : ((sl > e_speak) ? sl : e_speak);
    e_fpeak = (clr || err_clr) ? 0 : ((fl > e_fpeak) ? fl : e_fpeak);
    e_sovf = !clr && wr_en && s_fl;
    e_sudf = !clr && rd_en && s_em;
    e_fovf = !clr && wr_en && f_fl;
    e_fudf = !clr && rd_en && !f_ov;
    e_sst  = {e_sovf, e_sudf} | (err_clr ? 2'b00 : e_sst);
    e_fst  = {e_fovf, e_fudf} | (err_clr ? 2'b00 : e_fst);
    if (clr) begin
      sq.delete(); fq.delete(); f_ov = 0;
    end else begin
      if (rd_en && !s_em) e_srd = sq.pop_front();
      if (wr_en && !s_fl) sq.push_back(wr_data);
      // A word written this cycle can only reach the output from the next cycle on.
      rd_ok = rd_en && f_ov;
      fetch = (fq.size() > 0) && (!f_ov || rd_ok);
      if (fetch) begin
        e_frd = fq.pop_front(); f_ov = 1;
      end else if (rd_ok) begin
        f_ov = 0;
      end
      if (wr_en && !f_fl) fq.push_back(wr_data);
    end
    if (thr_wr) begin
      af_t = min_i(int'(af_in), DEPTH);
      ae_t = min_i(int'(ae_in), DEPTH);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sl, fl;
    sl = sq.size();
    fl = fq.size() + int'(f_ov);
    chk("s_rd_data",   32'(s_rd),    32'(e_srd));
    chk("s_rd_empty",  32'(s_empty), 32'(sl == 0));
    chk("s_wr_full",   32'(s_full),  32'(sl == DEPTH));
    chk("s_almost_full",  32'(s_af), 32'(sl >= af_t));
    chk("s_almost_empty", 32'(s_ae), 32'(sl <= ae_t));
    chk("s_level",     32'(s_lvl),   32'(sl));
    chk("s_overflow",  32'(s_ovf),   32'(e_sovf));
    chk("s_underflow", 32'(s_udf),   32'(e_sudf));
    chk("s_sticky",    32'(s_st),    32'(e_sst));
    chk("f_rd_data",   32'(f_rd),    32'(e_frd));
    chk("f_rd_empty",  32'(f_empty), 32'(!f_ov));
    chk("f_wr_full",   32'(f_full),  32'(fl == DEPTH));
    chk("f_almost_full",  32'(f_af), 32'(fl >= af_t));
    chk("f_almost_empty", 32'(f_ae), 32'(fl <= ae_t));
    chk("f_level",     32'(f_lvl),   32'(fl));
    chk("f_overflow",  32'(f_ovf),   32'(e_fovf));
    chk("f_underflow", 32'(f_udf),   32'(e_fudf));
    chk("f_sticky",    32'(f_st),    32'(e_fst));
`ifdef MAT_FIFO_PEAK_LEVEL_EN
    chk("s_peak", 32'(s_peak), 32'(e_speak));
    chk("f_peak", 32'(f_peak), 32'(e_fpeak));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit w, input bit r, input logic [DW-1:0] d);
    wr_en = w; rd_en = r; wr_data = d;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sq.size() > 0 || fq.size() > 0 || f_ov); i++) drive(0, 1, '0);
    drive(0, 0, '0);
  endtask

  initial begin
    logic [DW-1:0] cnt;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    // 1: fill to full then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, DW'(i));
      chk("t1_af_from_12", 32'(s_af), 32'(i + 1 >= 12));
    end
    chk("t1_full", 32'(s_full), 32'd1);
    chk("t1_level16", 32'(s_lvl), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, '0);
      chk("t1_rd_order", 32'(s_rd), 32'(i));
    end
    chk("t1_empty", 32'(s_empty), 32'd1);
    drain();

    // 2: FWFT latency from empty
    drive(1, 0, 8'hA5);
    chk("t2_n1_empty", 32'(f_empty), 32'd1);
    drive(0, 0, '0);
    chk("t2_n2_empty", 32'(f_empty), 32'd0);
    chk("t2_n2_data", 32'(f_rd), 32'hA5);
    drive(0, 1, '0);
    chk("t2_n3_empty", 32'(f_empty), 32'd1);
    drain();

    // 3: simultaneous rd/wr on full and on empty
    for (int i = 0; i < DEPTH; i++) drive(1, 0, DW'(8'h40 + i));
    drive(1, 1, 8'hEE);
    chk("t3_ovf", 32'(s_ovf), 32'd1);
    chk("t3_sticky", 32'(s_st), 32'b10);
    chk("t3_level", 32'(s_lvl), 32'd15);
    chk("t3_oldest", 32'(s_rd), 32'h40);
    chk("t3_f_ovf", 32'(f_ovf), 32'd1);
    err_clr = 1'b1; drive(0, 0, '0); err_clr = 1'b0;
    chk("t3_errclr", 32'(s_st), 32'd0);
    drain();
    drive(1, 1, 8'h77);
    chk("t3_udf", 32'(s_udf), 32'd1);
    chk("t3_udf_sticky", 32'(s_st), 32'b01);
    chk("t3_udf_level", 32'(s_lvl), 32'd1);
    chk("t3_f_udf", 32'(f_udf), 32'd1);
    drain();

    // 4: steady streaming at level 5 across pointer wrap
    cnt = '0;
    for (int i = 0; i < 5; i++) begin drive(1, 0, cnt); cnt++; end
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, cnt); cnt++;
      chk("t4_level", 32'(s_lvl), 32'd5);
      chk("t4_seq", 32'(s_rd), 32'(i));
    end
    drain();

    // 5: saturated thresholds
    thr_wr = 1'b1; af_in = 5'd20; ae_in = 5'd0;
    drive(0, 0, '0);
    thr_wr = 1'b0;
    chk("t5_af_empty", 32'(s_af), 32'd0);
    chk("t5_ae_empty", 32'(s_ae), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, DW'(i));
      if (i == 0)  chk("t5_ae_lvl1", 32'(s_ae), 32'd0);
      if (i == 14) chk("t5_af_lvl15", 32'(s_af), 32'd0);
    end
    chk("t5_af_full", 32'(s_af), 32'd1);
    drain();

    // 6: flush with write pending, then asynchronous reset mid-burst
    for (int i = 0; i < 9; i++) drive(1, 0, DW'(i));
    clr = 1'b1; drive(1, 0, 8'h99); clr = 1'b0;
    chk("t6_clr_level", 32'(s_lvl), 32'd0);
    chk("t6_clr_empty", 32'(s_empty), 32'd1);
    chk("t6_clr_no_ovf", 32'(s_ovf), 32'd0);
    for (int i = 0; i < 4; i++) drive(1, (i > 1), DW'(8'h20 + i));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_rst_level", 32'(f_lvl), 32'd0);
    rst_n = 1'b1;
    drive(1, 0, 8'h3C);
    chk("t6_first_wr", 32'(s_lvl), 32'd1);
    drain();

    // random traffic with occasional flush, threshold reload and error clear
    for (int i = 0; i < 600; i++) begin
      int wp, rp;
      wp = ((i / 100) % 2 == 0) ? 70 : 30;
      rp = 100 - wp;
      wr_en   = ($urandom_range(0, 99) < wp);
      rd_en   = ($urandom_range(0, 99) < rp);
      wr_data = DW'($urandom);
      clr     = ($urandom_range(0, 63) == 0);
      thr_wr  = ($urandom_range(0, 39) == 0);
      af_in   = LW'($urandom_range(0, 31));
      ae_in   = LW'($urandom_range(0, 31));
      err_clr = ($urandom_range(0, 29) == 0);
      step();
    end
    clr = 1'b0; thr_wr = 1'b0; err_clr = 1'b0;
    drive(0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
